// File: rtl/bi_fifo_pkg.sv
// rtl/bi_fifo_pkg.sv - shared constants and pointer helper for the bi_fifo controller family
package bi_fifo_pkg;

  // Cycles between memReadEnable and valid read data on the attached memory.
  localparam int MEM_READ_LATENCY = 1;

  // Number of words the output skid buffer can hold.
  localparam int SKID_DEPTH = 2;

  // Wrap-around increment for a pointer into a memory of arbitrary depth.
  function automatic logic [31:0] ptrInc(input logic [31:0] ptr, input logic [31:0] height);
    ptrInc = (ptr == height - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/bi_fifo_skid.sv
// rtl/bi_fifo_skid.sv - 2-entry output skid buffer fed by a latency-1 memory return
module bi_fifo_skid
  import bi_fifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic [1:0]       count
);

  // head is the word presented downstream; tail holds the second word.
  // The producer never offers a word when both slots stay occupied, so
  // there is no ready back to the producer.
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = head;
  assign pop      = m_tvalid & m_tready;

  // Slot update: capture into the first free slot, shift tail to head on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({s_tvalid, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head <= s_tdata;
          end else begin
            tail <= s_tdata;
          end
          if (count < 2'(SKID_DEPTH)) begin
            count <= count + 2'd1;
          end
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= s_tdata;
          end else begin
            head <= tail;
            tail <= s_tdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/bi_fifo_ctrl.sv
// rtl/bi_fifo_ctrl.sv - two-port memory FIFO controller; BI_FIFO_CTRL_LEVEL_EN adds level_o/almostFull_o
module bi_fifo_ctrl
  import bi_fifo_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int HEIGHT       = 16,
  parameter int AF_THRESHOLD = HEIGHT
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      pushValid_i,
  output logic                      pushReady_o,
  input  logic [WIDTH-1:0]          pushData_i,
  output logic                      popValid_o,
  input  logic                      popReady_i,
  output logic [WIDTH-1:0]          popData_o,
  output logic                      memReadEnable_o,
  output logic [$clog2(HEIGHT)-1:0] memReadAddr_o,
  input  logic [WIDTH-1:0]          memReadData_i,
  output logic                      memWriteEnable_o,
  output logic [$clog2(HEIGHT)-1:0] memWriteAddr_o,
  output logic [WIDTH-1:0]          memWriteData_o
`ifdef BI_FIFO_CTRL_LEVEL_EN
  ,
  output logic [$clog2(HEIGHT+3)-1:0] level_o,
  output logic                        almostFull_o
`endif
);

  localparam int AW = $clog2(HEIGHT);
  localparam int CW = $clog2(HEIGHT + 1);

  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [CW-1:0]               mem_count;
  logic [CW-1:0]               mem_count_next;
  logic [MEM_READ_LATENCY-1:0] in_flight;
  logic [1:0]                  buf_count;
  logic                        push_fire;
  logic                        pop_fire;
  logic                        fetch;

  // Handshakes. Only memory occupancy gates the write side; the skid
  // buffer is filled by prefetch and never blocks a push directly.
  assign pushReady_o = !reset_i && (mem_count < CW'(HEIGHT));
  assign push_fire   = pushValid_i & pushReady_o;
  assign pop_fire    = popValid_o & popReady_i;

  // Prefetch whenever memory holds data and the word would have a skid
  // slot to land in, counting the slot a pop frees this same cycle.
  assign fetch = (mem_count != '0) &&
                 (({1'b0, buf_count} + {2'b00, in_flight[0]}) <
                  (3'(SKID_DEPTH) + {2'b00, pop_fire}));

  assign memWriteEnable_o = push_fire;
  assign memWriteAddr_o   = wr_ptr;
  assign memWriteData_o   = reset_i ? '0 : pushData_i;
  assign memReadEnable_o  = fetch;
  assign memReadAddr_o    = rd_ptr;

  // Memory occupancy after this cycle's push and fetch.
  always_comb begin
    mem_count_next = mem_count;
    case ({push_fire, fetch})
      2'b10:   mem_count_next = mem_count + CW'(1);
      2'b01:   mem_count_next = mem_count - CW'(1);
      default: mem_count_next = mem_count;
    endcase
  end

  // Pointers, memory occupancy and the read-return marker; clear wins over all traffic.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      in_flight <= '0;
    end else if (clear_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      in_flight <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= AW'(ptrInc(32'(wr_ptr), 32'(HEIGHT)));
      end
      if (fetch) begin
        rd_ptr <= AW'(ptrInc(32'(rd_ptr), 32'(HEIGHT)));
      end
      mem_count <= mem_count_next;
      in_flight <= fetch;
    end
  end

  // Read data is only captured in the cycle its fetch marker is set, and
  // is dropped if a clear lands in that cycle.
  bi_fifo_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk_i),
    .rst      (reset_i),
    .clear    (clear_i),
    .s_tvalid (in_flight[0]),
    .s_tdata  (memReadData_i),
    .m_tvalid (popValid_o),
    .m_tready (popReady_i),
    .m_tdata  (popData_o),
    .count    (buf_count)
  );

`ifdef BI_FIFO_CTRL_LEVEL_EN
  localparam int LW = $clog2(HEIGHT + 3);

  logic [LW-1:0] occ_next;
  logic [LW-1:0] level_q;
  logic          almost_full_q;

  assign level_o      = level_q;
  assign almostFull_o = almost_full_q;

  // Occupancy the state will hold after this edge, so the registered
  // level matches the current contents rather than lagging by a cycle.
  always_comb begin
    occ_next = '0;
    if (!clear_i) begin
      occ_next = LW'(mem_count_next) + LW'(fetch) + LW'(buf_count) +
                 LW'(in_flight[0]) - LW'(pop_fire);
    end
  end

  // Registered level and threshold flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= occ_next;
      almost_full_q <= (int'(occ_next) >= AF_THRESHOLD);
    end
  end
`else
  // The threshold has no effect without the level feature.
  if (AF_THRESHOLD < 0) begin : g_af_ignored
  end
`endif

endmodule
